// File: rtl/sdram_responder.sv
// sdram_responder: single-chip SDR SDRAM device model for exercising a memory
// controller. It decodes the command pins, tracks open banks and rows, stores
// byte-masked writes, and returns read data after the programmed CAS latency
// (2 or 3) through a bubble-free pipeline.
// Optional protocol checker: define SDRAM_RESPONDER_CHECK_EN to build it.
// When it is not defined, cmd_err and err_code are tied to zero.
module sdram_responder #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic [11:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_dqmh_n,
  input  logic        sdram_dqml_n,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dq_oe,
  output logic        init_done,
  output logic [3:0]  bank_open,
  output logic        cmd_err,
  output logic [2:0]  err_code
);
  localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_REFRESH,
    CMD_LOAD_MODE
  } cmd_e;

  cmd_e                cmd_s;
  logic [15:0]         mem_q [DEPTH];
  logic [3:0]          bank_open_q, bank_open_d;
  logic [ROW_BITS-1:0] open_row_q [4];
  logic [ROW_BITS-1:0] open_row_d [4];
  logic                cl3_q, cl3_d;
  logic [1:0]          ref_cnt_q, ref_cnt_d;
  logic                init_done_q, init_done_d;
  logic                p1_v_q, p1_v_d, p2_v_q, p2_v_d;
  logic [15:0]         p1_data_q, p1_data_d, p2_data_q, p2_data_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_o_q, dq_o_d;
  logic [IDX_BITS-1:0] idx_s;
  logic                bank_hit_s;
  logic [15:0]         rd_data_s;
  logic                wr_en_s;
  logic                unused_addr_s;

  // Only some address bits matter for a given command; fold the rest away.
  assign unused_addr_s = ^sdram_addr;

  // Command decode; CKE low or chip deselect reads as NOP.
  always_comb begin
    cmd_s = CMD_NOP;
    if (sdram_cke && !sdram_cs_n) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  cmd_s = CMD_ACTIVE;
        3'b101:  cmd_s = CMD_READ;
        3'b100:  cmd_s = CMD_WRITE;
        3'b010:  cmd_s = CMD_PRECHARGE;
        3'b001:  cmd_s = CMD_REFRESH;
        3'b000:  cmd_s = CMD_LOAD_MODE;
        default: cmd_s = CMD_NOP;
      endcase
    end else begin
      cmd_s = CMD_NOP;
    end
  end

  assign bank_hit_s = bank_open_q[sdram_ba];
  assign idx_s      = {sdram_ba, open_row_q[sdram_ba], sdram_addr[COL_BITS-1:0]};
  assign rd_data_s  = bank_hit_s ? mem_q[idx_s] : 16'h0000;
  assign wr_en_s    = (cmd_s == CMD_WRITE) && bank_hit_s;

  // Byte-masked storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_s) begin
      if (!sdram_dqml_n) mem_q[idx_s][7:0]  <= dq_i[7:0];
      if (!sdram_dqmh_n) mem_q[idx_s][15:8] <= dq_i[15:8];
    end
  end

  // Bank, mode and init-sequence next state from the decoded command.
  always_comb begin
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    cl3_d       = cl3_q;
    ref_cnt_d   = ref_cnt_q;
    init_done_d = init_done_q;
    case (cmd_s)
      CMD_ACTIVE: begin
        bank_open_d[sdram_ba] = 1'b1;
        open_row_d[sdram_ba]  = sdram_addr[ROW_BITS-1:0];
      end
      CMD_PRECHARGE: begin
        if (sdram_addr[10]) bank_open_d = 4'b0000;
        else                bank_open_d[sdram_ba] = 1'b0;
      end
      CMD_REFRESH: begin
        if (ref_cnt_q != 2'd2) ref_cnt_d = ref_cnt_q + 2'd1;
        else                   ref_cnt_d = ref_cnt_q;
      end
      CMD_LOAD_MODE: begin
        if (sdram_addr[6:4] == 3'd2)      cl3_d = 1'b0;
        else if (sdram_addr[6:4] == 3'd3) cl3_d = 1'b1;
        else                              cl3_d = cl3_q;
        if (ref_cnt_q == 2'd2) init_done_d = 1'b1;
        else                   init_done_d = init_done_q;
      end
      default: ;
    endcase
  end

  // Read pipeline: stage 1 captures the read, output taps stage 1 (CL2) or 2 (CL3).
  always_comb begin
    p1_v_d    = p1_v_q;
    p1_data_d = p1_data_q;
    p2_v_d    = p2_v_q;
    p2_data_d = p2_data_q;
    dq_oe_d   = dq_oe_q;
    dq_o_d    = dq_o_q;
    if (sdram_cke) begin
      p1_v_d    = (cmd_s == CMD_READ);
      p1_data_d = (cmd_s == CMD_READ) ? rd_data_s : 16'h0000;
      p2_v_d    = p1_v_q;
      p2_data_d = p1_data_q;
      if (cl3_q) begin
        dq_oe_d = p2_v_q;
        dq_o_d  = p2_data_q;
      end else begin
        dq_oe_d = p1_v_q;
        dq_o_d  = p1_data_q;
      end
    end else begin
      dq_oe_d = dq_oe_q;
      dq_o_d  = dq_o_q;
    end
  end

  // State registers with synchronous reset; the pipeline is flushed on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_open_q <= 4'b0000;
      open_row_q  <= '{default: '0};
      cl3_q       <= 1'b0;
      ref_cnt_q   <= 2'd0;
      init_done_q <= 1'b0;
      p1_v_q      <= 1'b0;
      p1_data_q   <= 16'h0000;
      p2_v_q      <= 1'b0;
      p2_data_q   <= 16'h0000;
      dq_oe_q     <= 1'b0;
      dq_o_q      <= 16'h0000;
    end else begin
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      cl3_q       <= cl3_d;
      ref_cnt_q   <= ref_cnt_d;
      init_done_q <= init_done_d;
      p1_v_q      <= p1_v_d;
      p1_data_q   <= p1_data_d;
      p2_v_q      <= p2_v_d;
      p2_data_q   <= p2_data_d;
      dq_oe_q     <= dq_oe_d;
      dq_o_q      <= dq_o_d;
    end
  end

  assign dq_o      = dq_o_q;
  assign dq_oe     = dq_oe_q;
  assign init_done = init_done_q;
  assign bank_open = bank_open_q;

`ifdef SDRAM_RESPONDER_CHECK_EN
  logic       cmd_err_q;
  logic [2:0] err_code_q;
  logic [2:0] viol_code_s;

  // Classify the current command against protocol rules; 0 means legal.
  always_comb begin
    viol_code_s = 3'd0;
    case (cmd_s)
      CMD_READ, CMD_WRITE: begin
        if (!bank_hit_s)                              viol_code_s = 3'd1;
        else if (!init_done_q)                        viol_code_s = 3'd4;
        else if ((cmd_s == CMD_WRITE) && dq_oe_q)     viol_code_s = 3'd5;
        else                                          viol_code_s = 3'd0;
      end
      CMD_ACTIVE: begin
        if (bank_hit_s)        viol_code_s = 3'd2;
        else if (!init_done_q) viol_code_s = 3'd4;
        else                   viol_code_s = 3'd0;
      end
      CMD_LOAD_MODE: begin
        if (((sdram_addr[6:4] != 3'd2) && (sdram_addr[6:4] != 3'd3)) ||
            (sdram_addr[2:0] != 3'b000)) viol_code_s = 3'd3;
        else                             viol_code_s = 3'd0;
      end
      CMD_REFRESH: begin
        if (bank_open_q != 4'b0000) viol_code_s = 3'd6;
        else                        viol_code_s = 3'd0;
      end
      default: viol_code_s = 3'd0;
    endcase
  end

  // Sticky error flag: only the first violation since reset is latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_err_q  <= 1'b0;
      err_code_q <= 3'd0;
    end else if (!cmd_err_q && (viol_code_s != 3'd0)) begin
      cmd_err_q  <= 1'b1;
      err_code_q <= viol_code_s;
    end
  end

  assign cmd_err  = cmd_err_q;
  assign err_code = err_code_q;
`else
  assign cmd_err  = 1'b0;
  assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios plus randomized commands,
// compared every cycle against a transaction-level device model.
module tb_sdram_responder;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000, C_ALT = 4'b0110, C_DES = 4'b1111;
`ifdef SDRAM_RESPONDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        sdram_dqmh_n, sdram_dqml_n;
  logic [15:0] dq_i, dq_o;
  logic        dq_oe, init_done, cmd_err;
  logic [3:0]  bank_open;
  logic [2:0]  err_code;

  sdram_responder dut (
    .clk(clk), .reset(reset), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba), .sdram_dqmh_n(sdram_dqmh_n),
    .sdram_dqml_n(sdram_dqml_n), .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe),
    .init_done(init_done), .bank_open(bank_open), .cmd_err(cmd_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct { logic [15:0] d; logic [15:0] m; int cnt; } rd_t;
  rd_t         q[$];
  logic [15:0] mm [1024];
  bit          kl [1024];
  bit          kh [1024];
  bit          m_open [4];
  int          m_row [4];
  int          m_cl, m_refs, m_code;
  bit          m_init, m_err, m_quiet;
  logic        exp_oe;
  logic [15:0] exp_dq, exp_mask;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit pin_oe_en, pin_dq_en, pin_init_en, pin_bank_en, pin_err_en;
  logic        pin_oe, pin_init, pin_err;
  logic [15:0] pin_dq;
  logic [3:0]  pin_bank;
  logic [2:0]  pin_code;

  // Advance the model by one clock edge using the currently driven pins.
  task automatic model_edge();
    logic [3:0] c;
    int ba, a, key, vc, v;
    rd_t e;
    if (reset) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      m_cl = 2; m_refs = 0; m_init = 1'b0; m_err = 1'b0; m_code = 0; m_quiet = 1'b1;
      exp_oe = 1'b0; exp_dq = 16'h0000; exp_mask = 16'hFFFF;
      return;
    end
    if (!sdram_cke) return;
    c   = sdram_cs_n ? C_NOP : {1'b0, sdram_ras_n, sdram_cas_n, sdram_we_n};
    ba  = int'(sdram_ba);
    a   = int'(sdram_addr);
    key = ba * 256 + (m_row[ba] % 4) * 64 + (a % 64);
    vc  = 0;
    case (c)
      C_RD, C_WR: if (!m_open[ba]) vc = 1; else if (!m_init) vc = 4;
                  else if (c == C_WR && exp_oe) vc = 5;
      C_ACT:      if (m_open[ba]) vc = 2; else if (!m_init) vc = 4;
      C_LMR:      if (!(((a >> 4) % 8) == 2 || ((a >> 4) % 8) == 3) || (a % 8) != 0) vc = 3;
      C_REF:      if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) vc = 6;
      default: ;
    endcase
    if (CHK && !m_err && vc != 0) begin m_err = 1'b1; m_code = vc; end
    for (int i = 0; i < q.size(); i++) q[i].cnt = q[i].cnt - 1;
    if (q.size() > 0 && q[0].cnt == 0) begin
      exp_oe = 1'b1; exp_dq = q[0].d; exp_mask = q[0].m; m_quiet = 1'b0;
      void'(q.pop_front());
    end else begin
      exp_oe = 1'b0; exp_dq = 16'h0000; exp_mask = m_quiet ? 16'hFFFF : 16'h0000;
    end
    case (c)
      C_ACT: begin m_open[ba] = 1'b1; m_row[ba] = a; end
      C_PRE: if (sdram_addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
             else m_open[ba] = 1'b0;
      C_REF: if (m_refs < 2) m_refs = m_refs + 1;
      C_LMR: begin
        v = (a >> 4) % 8;
        if (v == 2 || v == 3) m_cl = v;
        if (m_refs >= 2) m_init = 1'b1;
      end
      C_WR: if (m_open[ba]) begin
        if (!sdram_dqml_n) begin mm[key][7:0]  = dq_i[7:0];  kl[key] = 1'b1; end
        if (!sdram_dqmh_n) begin mm[key][15:8] = dq_i[15:8]; kh[key] = 1'b1; end
      end
      C_RD: begin
        e.cnt = m_cl - 1;
        if (m_open[ba]) begin
          e.d = mm[key];
          e.m = {kh[key] ? 8'hFF : 8'h00, kl[key] ? 8'hFF : 8'h00};
        end else begin
          e.d = 16'h0000; e.m = 16'hFFFF;
        end
        q.push_back(e);
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model every cycle, plus any literal pins for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("dq_oe", {15'h0000, dq_oe}, {15'h0000, exp_oe});
        chk("dq_o", dq_o & exp_mask, exp_dq & exp_mask);
        chk("bank_open", {12'h000, bank_open}, {12'h000, m_open[3], m_open[2], m_open[1], m_open[0]});
        chk("init_done", {15'h0000, init_done}, {15'h0000, m_init});
        chk("cmd_err", {15'h0000, cmd_err}, {15'h0000, m_err});
        chk("err_code", {13'h0000, err_code}, 16'(m_code));
        if (pin_oe_en)   chk("pin_dq_oe", {15'h0000, dq_oe}, {15'h0000, pin_oe});
        if (pin_dq_en)   chk("pin_dq_o", dq_o, pin_dq);
        if (pin_init_en) chk("pin_init_done", {15'h0000, init_done}, {15'h0000, pin_init});
        if (pin_bank_en) chk("pin_bank_open", {12'h000, bank_open}, {12'h000, pin_bank});
        if (pin_err_en) begin
          chk("pin_cmd_err", {15'h0000, cmd_err}, {15'h0000, pin_err});
          chk("pin_err_code", {13'h0000, err_code}, {13'h0000, pin_code});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic rst, input logic cke, input logic [3:0] c,
                      input logic [1:0] ba, input logic [11:0] addr, input logic [15:0] d,
                      input logic dqmh_n, input logic dqml_n);
    @(negedge clk); #1;
    pin_oe_en = 1'b0; pin_dq_en = 1'b0; pin_init_en = 1'b0; pin_bank_en = 1'b0; pin_err_en = 1'b0;
    reset = rst; sdram_cke = cke;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba = ba; sdram_addr = addr; dq_i = d;
    sdram_dqmh_n = dqmh_n; sdram_dqml_n = dqml_n;
    model_edge();
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] addr,
                     input logic [15:0] d);
    step(1'b0, 1'b1, c, ba, addr, d, 1'b0, 1'b0);
  endtask

  task automatic p_oe(input logic oe);
    pin_oe_en = 1'b1; pin_oe = oe;
  endtask
  task automatic p_out(input logic [15:0] d);
    pin_oe_en = 1'b1; pin_oe = 1'b1; pin_dq_en = 1'b1; pin_dq = d;
  endtask
  task automatic p_rst();
    pin_oe_en = 1'b1; pin_oe = 1'b0; pin_dq_en = 1'b1; pin_dq = 16'h0000;
    pin_init_en = 1'b1; pin_init = 1'b0; pin_bank_en = 1'b1; pin_bank = 4'b0000;
    pin_err_en = 1'b1; pin_err = 1'b0; pin_code = 3'd0;
  endtask

  task automatic do_init();
    cmd(C_REF, 2'd0, 12'h000, 16'h0000);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000);
    cmd(C_REF, 2'd0, 12'h000, 16'h0000);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000);
    cmd(C_LMR, 2'd0, 12'h020, 16'h0000);
    pin_init_en = 1'b1; pin_init = 1'b1;
  endtask

  logic [15:0] w4 [4];
  logic [11:0] ra;
  logic [3:0]  rc;
  int r;

  initial begin
    w4[0] = 16'h1357; w4[1] = 16'h2468; w4[2] = 16'h9ABC; w4[3] = 16'hDEF0;
    // Reset state
    step(1'b1, 1'b1, C_NOP, 2'd0, 12'h000, 16'h0000, 1'b1, 1'b1);
    chk_en = 1'b1; p_rst();
    step(1'b1, 1'b1, C_NOP, 2'd0, 12'h000, 16'h0000, 1'b1, 1'b1); p_rst();
    // Init sequence, CL=2
    do_init();
    cmd(C_ACT, 2'd1, 12'h003, 16'h0000); pin_bank_en = 1'b1; pin_bank = 4'b0010;
    cmd(C_WR,  2'd1, 12'h005, 16'hA55A);
    cmd(C_RD,  2'd1, 12'h005, 16'h0000); p_oe(1'b0);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_out(16'hA55A);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_oe(1'b0);
    // CL=3, masked write over 16'hFFFF
    cmd(C_LMR, 2'd0, 12'h030, 16'h0000);
    cmd(C_WR,  2'd1, 12'h006, 16'hFFFF);
    step(1'b0, 1'b1, C_WR, 2'd1, 12'h006, 16'h1234, 1'b1, 1'b0);
    cmd(C_RD,  2'd1, 12'h006, 16'h0000); p_oe(1'b0);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_oe(1'b0);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_out(16'hFF34);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_oe(1'b0);
    // Four back-to-back reads at CL=3
    for (int i = 0; i < 4; i++) cmd(C_WR, 2'd1, 12'(8 + i), w4[i]);
    cmd(C_RD, 2'd1, 12'd8, 16'h0000);  p_oe(1'b0);
    cmd(C_RD, 2'd1, 12'd9, 16'h0000);  p_oe(1'b0);
    cmd(C_RD, 2'd1, 12'd10, 16'h0000); p_out(w4[0]);
    cmd(C_RD, 2'd1, 12'd11, 16'h0000); p_out(w4[1]);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_out(w4[2]);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_out(w4[3]);
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_oe(1'b0);
    // Reset one cycle after a CL=3 read
    cmd(C_RD, 2'd1, 12'h005, 16'h0000);
    step(1'b1, 1'b1, C_NOP, 2'd0, 12'h000, 16'h0000, 1'b1, 1'b1); p_rst();
    for (int i = 0; i < 4; i++) begin
      cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_rst();
    end
    // Closed-bank access and sticky error code
    do_init();
    cmd(C_PRE, 2'd0, 12'h400, 16'h0000); pin_bank_en = 1'b1; pin_bank = 4'b0000;
    cmd(C_RD,  2'd0, 12'h001, 16'h0000);
    pin_err_en = 1'b1; pin_err = CHK; pin_code = CHK ? 3'd1 : 3'd0;
    cmd(C_NOP, 2'd0, 12'h000, 16'h0000); p_out(16'h0000);
    cmd(C_ACT, 2'd2, 12'h001, 16'h0000);
    cmd(C_ACT, 2'd2, 12'h001, 16'h0000);
    pin_err_en = 1'b1; pin_err = CHK; pin_code = CHK ? 3'd1 : 3'd0;
    // Randomized traffic
    step(1'b1, 1'b1, C_NOP, 2'd0, 12'h000, 16'h0000, 1'b1, 1'b1);
    do_init();
    for (int i = 0; i < 2500; i++) begin
      r  = $urandom_range(0, 99);
      ra = 12'($urandom);
      if ($urandom_range(0, 1) == 0) ra[5:0] = 6'($urandom_range(0, 7));
      if (r < 30)      rc = C_RD;
      else if (r < 55) rc = C_WR;
      else if (r < 65) rc = C_ACT;
      else if (r < 72) begin rc = C_PRE; ra[10] = ($urandom_range(0, 4) == 0); end
      else if (r < 80) rc = C_NOP;
      else if (r < 84) rc = C_DES;
      else if (r < 86) rc = C_ALT;
      else if (r < 93) rc = 4'($urandom);
      else if (r < 95) rc = C_REF;
      else if (r < 98) begin
        rc = (q.size() == 0) ? C_LMR : C_NOP;
        ra[6:4] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(2, 3));
        ra[2:0] = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b000;
      end else rc = C_NOP;
      if (r == 99)
        step(1'b1, 1'b1, C_NOP, 2'($urandom), ra, 16'($urandom), 1'b1, 1'b1);
      else
        step(1'b0, (r < 86 || r >= 93), rc, 2'($urandom), ra, 16'($urandom),
             1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 4; i++) cmd(C_NOP, 2'd0, 12'h000, 16'h0000);
    @(negedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
